// File: rtl/apb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : apb_pkg                                                         |
// | Brief    : Shared types and constants for the APB master arbiter.          |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package apb_pkg;

    localparam int                  APB_ID_W      = 2;
    localparam logic [APB_ID_W-1:0] APB_ID_NONE   = 2'b00;
    localparam int                  TIMEOUT_CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

endpackage : apb_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : rr_arbiter                                                      |
// | Brief    : Round-robin grant selection with a last-grant pointer register. |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] eligible,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    logic [IDX_W-1:0] r_last;
    logic             w_found;
    int               w_cand;

    // Search starts one past the last winner so nobody wins twice while others wait.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        w_found   = 1'b0;
        w_cand    = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_cand = (int'(r_last) + k) % NUM_REQ;
            if (enable && !w_found && eligible[w_cand]) begin
                w_found         = 1'b1;
                grant[w_cand]   = 1'b1;
                grant_idx       = IDX_W'(w_cand);
            end
        end
    end

    // Resetting to the last index makes requester 0 the first candidate.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_last <= IDX_W'(NUM_REQ - 1);
        end else if (w_found) begin
            r_last <= grant_idx;
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/apb_master_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : apb_master_arbiter                                              |
// | Brief    : Round-robin sharing of one APB bus with SETUP/ACCESS sequencing.|
// |            Optional ACCESS wait timeout enabled by macro APB_TIMEOUT_EN.   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module apb_master_arbiter
    import apb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 255
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ-1:0]           req_write,
    input  logic [APB_ID_W*NUM_REQ-1:0]  req_id,
    input  logic [ADDR_W*NUM_REQ-1:0]    req_addr,
    input  logic [DATA_W*NUM_REQ-1:0]    req_wdata,
    output logic [NUM_REQ-1:0]           req_done,
    output logic [DATA_W-1:0]            rsp_rdata,
    output logic                         rsp_err,
    output logic [APB_ID_W-1:0]          apb_sel,
    output logic                         apb_enable,
    output logic                         apb_write,
    output logic [ADDR_W-1:0]            apb_addr,
    output logic [DATA_W-1:0]            apb_wdata,
    input  logic [DATA_W-1:0]            apb_rdata,
    input  logic                         apb_ready
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    apb_state_t          r_state;
    apb_state_t          w_next_state;

    logic [NUM_REQ-1:0]  w_eligible;
    logic [NUM_REQ-1:0]  w_grant;
    logic [IDX_W-1:0]    w_grant_idx;
    logic                w_arb_en;

    logic [APB_ID_W-1:0] w_id_arr    [NUM_REQ];
    logic [ADDR_W-1:0]   w_addr_arr  [NUM_REQ];
    logic [DATA_W-1:0]   w_wdata_arr [NUM_REQ];
    logic                w_gnt_write;
    logic [APB_ID_W-1:0] w_gnt_id;
    logic [ADDR_W-1:0]   w_gnt_addr;
    logic [DATA_W-1:0]   w_gnt_wdata;

    logic [NUM_REQ-1:0]  r_gnt_oh;
    logic                r_write;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [APB_ID_W-1:0] r_sel;
    logic                r_enable;
    logic [NUM_REQ-1:0]  r_done;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_err;

    logic                w_load;
    logic [APB_ID_W-1:0] w_nxt_sel;
    logic                w_nxt_enable;
    logic [NUM_REQ-1:0]  w_nxt_done;
    logic [DATA_W-1:0]   w_nxt_rdata;
    logic                w_nxt_err;

`ifdef APB_TIMEOUT_EN
    localparam logic [TIMEOUT_CNT_W-1:0] C_WAIT_LIMIT = TIMEOUT_CNT_W'(TIMEOUT - 1);
    logic [TIMEOUT_CNT_W-1:0] r_wait_cnt;
    logic [TIMEOUT_CNT_W-1:0] w_nxt_wait_cnt;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT != 0);
`endif

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign w_id_arr[i]    = req_id[i*APB_ID_W +: APB_ID_W];
        assign w_addr_arr[i]  = req_addr[i*ADDR_W +: ADDR_W];
        assign w_wdata_arr[i] = req_wdata[i*DATA_W +: DATA_W];
    end

    assign w_gnt_write = req_write[w_grant_idx];
    assign w_gnt_id    = w_id_arr[w_grant_idx];
    assign w_gnt_addr  = w_addr_arr[w_grant_idx];
    assign w_gnt_wdata = w_wdata_arr[w_grant_idx];

    // The requester finishing this cycle still shows req_valid, so hide it.
    assign w_eligible = req_valid & ~r_done;
    assign w_arb_en   = (r_state == IDLE);

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .clk       (clk),
        .reset     (reset),
        .eligible  (w_eligible),
        .enable    (w_arb_en),
        .grant     (w_grant),
        .grant_idx (w_grant_idx)
    );

    always_comb begin
        w_next_state   = r_state;
        w_load         = 1'b0;
        w_nxt_sel      = r_sel;
        w_nxt_enable   = r_enable;
        w_nxt_done     = '0;
        w_nxt_rdata    = r_rdata;
        w_nxt_err      = r_err;
`ifdef APB_TIMEOUT_EN
        w_nxt_wait_cnt = r_wait_cnt;
`endif
        case (r_state)
            IDLE: begin
                w_nxt_sel    = '0;
                w_nxt_enable = 1'b0;
                if (|w_grant) begin
                    w_load = 1'b1;
                    // An unselected slave id completes at once as an error, no bus cycle.
                    if (w_gnt_id == APB_ID_NONE) begin
                        w_nxt_done  = w_grant;
                        w_nxt_err   = 1'b1;
                        w_nxt_rdata = '0;
                    end else begin
                        w_next_state = SETUP;
                        w_nxt_sel    = w_gnt_id;
                    end
                end
            end
            SETUP: begin
                w_next_state   = ACCESS;
                w_nxt_enable   = 1'b1;
`ifdef APB_TIMEOUT_EN
                w_nxt_wait_cnt = '0;
`endif
            end
            ACCESS: begin
                if (apb_ready) begin
                    w_next_state = IDLE;
                    w_nxt_sel    = '0;
                    w_nxt_enable = 1'b0;
                    w_nxt_done   = r_gnt_oh;
                    w_nxt_rdata  = r_write ? '0 : apb_rdata;
                    w_nxt_err    = 1'b0;
                end
`ifdef APB_TIMEOUT_EN
                else if (r_wait_cnt == C_WAIT_LIMIT) begin
                    w_next_state = IDLE;
                    w_nxt_sel    = '0;
                    w_nxt_enable = 1'b0;
                    w_nxt_done   = r_gnt_oh;
                    w_nxt_rdata  = '0;
                    w_nxt_err    = 1'b1;
                end else begin
                    w_nxt_wait_cnt = r_wait_cnt + 1'b1;
                end
`endif
            end
            default: begin
                w_next_state = IDLE;
                w_nxt_sel    = '0;
                w_nxt_enable = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_sel      <= '0;
            r_enable   <= 1'b0;
            r_done     <= '0;
            r_rdata    <= '0;
            r_err      <= 1'b0;
`ifdef APB_TIMEOUT_EN
            r_wait_cnt <= '0;
`endif
        end else begin
            r_state    <= w_next_state;
            r_sel      <= w_nxt_sel;
            r_enable   <= w_nxt_enable;
            r_done     <= w_nxt_done;
            r_rdata    <= w_nxt_rdata;
            r_err      <= w_nxt_err;
`ifdef APB_TIMEOUT_EN
            r_wait_cnt <= w_nxt_wait_cnt;
`endif
        end
    end

    // Only the granted requester's fields are ever captured.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_gnt_oh <= '0;
            r_write  <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
        end else if (w_load) begin
            r_gnt_oh <= w_grant;
            r_write  <= w_gnt_write;
            r_addr   <= w_gnt_addr;
            r_wdata  <= w_gnt_wdata;
        end
    end

    assign req_done   = r_done;
    assign rsp_rdata  = r_rdata;
    assign rsp_err    = r_err;
    assign apb_sel    = r_sel;
    assign apb_enable = r_enable;
    assign apb_write  = r_write;
    assign apb_addr   = r_addr;
    assign apb_wdata  = r_wdata;

endmodule : apb_master_arbiter
`default_nettype wire

// File: tb/tb_apb_master_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_apb_master_arbiter                                           |
// | Brief    : Directed and random transfers against a transaction-level model.|
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_apb_master_arbiter;

    localparam int NUM_REQ = 3;
    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 8;
    localparam int TIMEOUT = 8;

    logic                       clk = 1'b0;
    logic                       reset;
    logic [NUM_REQ-1:0]         req_valid, req_write, req_done;
    logic [2*NUM_REQ-1:0]       req_id;
    logic [ADDR_W*NUM_REQ-1:0]  req_addr;
    logic [DATA_W*NUM_REQ-1:0]  req_wdata;
    logic [DATA_W-1:0]          rsp_rdata, apb_wdata, apb_rdata;
    logic                       rsp_err, apb_enable, apb_write, apb_ready;
    logic [1:0]                 apb_sel;
    logic [ADDR_W-1:0]          apb_addr;

    always #5 clk = ~clk;

    apb_master_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_write  (req_write),
        .req_id     (req_id),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_done   (req_done),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .apb_sel    (apb_sel),
        .apb_enable (apb_enable),
        .apb_write  (apb_write),
        .apb_addr   (apb_addr),
        .apb_wdata  (apb_wdata),
        .apb_rdata  (apb_rdata),
        .apb_ready  (apb_ready)
    );

    int checks = 0;
    int errors = 0;

    // Requester side of the model
    logic [NUM_REQ-1:0] m_valid;
    logic               m_write [NUM_REQ];
    logic [1:0]         m_id    [NUM_REQ];
    logic [ADDR_W-1:0]  m_addr  [NUM_REQ];
    logic [DATA_W-1:0]  m_wdata [NUM_REQ];
    int                 m_left  [NUM_REQ];
    bit                 rnd_en = 1'b0;

    // Transfer currently expected on the bus, described by its cycle timeline
    int                 cyc = 0;
    int                 last;
    bit                 t_act = 1'b0;
    int                 t_g, t_t0, t_w, t_done;
    logic               t_write, t_abort;
    logic [1:0]         t_id;
    logic [ADDR_W-1:0]  t_addr;
    logic [DATA_W-1:0]  t_wdata, t_rd;
    int                 reload_g = -1;
    int                 w_q [$];
    bit                 rd_force_en = 1'b0;
    logic [DATA_W-1:0]  rd_force = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic drive();
        for (int r = 0; r < NUM_REQ; r++) begin
            req_valid[r]                = m_valid[r];
            req_write[r]                = m_write[r];
            req_id[2*r +: 2]            = m_id[r];
            req_addr[ADDR_W*r +: ADDR_W] = m_addr[r];
            req_wdata[DATA_W*r +: DATA_W] = m_wdata[r];
        end
    endtask

    task automatic rand_fields(input int r);
        m_write[r] = 1'($urandom);
        m_id[r]    = ($urandom_range(0, 7) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
        m_addr[r]  = ADDR_W'($urandom);
        m_wdata[r] = DATA_W'($urandom);
    endtask

    task automatic set_req(input int r, input logic wr, input logic [1:0] id,
                           input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wd,
                           input int left);
        m_valid[r] = 1'b1; m_write[r] = wr; m_id[r] = id;
        m_addr[r]  = addr; m_wdata[r] = wd; m_left[r] = left;
        drive();
    endtask

    function automatic int pick_w();
`ifdef APB_TIMEOUT_EN
        if ($urandom_range(0, 5) == 0) return TIMEOUT - 1 + $urandom_range(0, 2);
`endif
        return $urandom_range(0, 3);
    endfunction

    task automatic start_xfer(input int g);
        t_act = 1'b1; t_g = g; t_t0 = cyc; last = g;
        t_write = m_write[g]; t_id = m_id[g]; t_addr = m_addr[g]; t_wdata = m_wdata[g];
        t_abort = 1'b0; t_rd = '0; t_w = 0;
        if (t_id == 2'd0) begin
            t_done = cyc + 1;
        end else begin
            t_w    = (w_q.size() > 0) ? w_q.pop_front() : pick_w();
            t_done = cyc + 3 + t_w;
`ifdef APB_TIMEOUT_EN
            if (t_w >= TIMEOUT) begin
                t_abort = 1'b1;
                t_done  = cyc + 2 + TIMEOUT;
            end
`endif
        end
    endtask

    task automatic step();
        logic [NUM_REQ-1:0] elig;
        logic [1:0]         e_sel;
        logic               e_en;
        logic [NUM_REQ-1:0] e_done;
        int                 do_reload;
        // Arbitration for the cycle now ending: first eligible after the last winner
        if (!t_act || cyc >= t_done) begin
            elig = m_valid;
            if (t_act && cyc == t_done) elig[t_g] = 1'b0;
            for (int k = 1; k <= NUM_REQ; k++) begin
                int g;
                g = (last + k) % NUM_REQ;
                if (elig[g]) begin
                    start_xfer(g);
                    break;
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        do_reload = reload_g;
        reload_g  = -1;
        e_sel = '0; e_en = 1'b0; e_done = '0;
        if (t_act) begin
            if (t_id != 2'd0 && cyc == t_t0 + 1) begin
                e_sel = t_id;
            end else if (t_id != 2'd0 && cyc >= t_t0 + 2 && cyc < t_done) begin
                e_sel = t_id;
                e_en  = 1'b1;
            end
            if (cyc == t_done) e_done[t_g] = 1'b1;
        end
        chk("apb_sel", 32'(apb_sel), 32'(e_sel));
        chk("apb_enable", 32'(apb_enable), 32'(e_en));
        chk("req_done", 32'(req_done), 32'(e_done));
        if (e_sel != 2'd0) begin
            chk("apb_addr", 32'(apb_addr), 32'(t_addr));
            chk("apb_wdata", 32'(apb_wdata), 32'(t_wdata));
            chk("apb_write", 32'(apb_write), 32'(t_write));
        end
        if (e_done != '0) begin
            chk("rsp_rdata", 32'(rsp_rdata),
                (t_write || t_abort || t_id == 2'd0) ? 32'd0 : 32'(t_rd));
            chk("rsp_err", 32'(rsp_err), 32'(t_abort || t_id == 2'd0));
            m_left[t_g]--;
            reload_g = t_g;
        end
        // Requester that finished last cycle either issues its next request or drops
        if (do_reload >= 0) begin
            if (m_left[do_reload] > 0) rand_fields(do_reload);
            else m_valid[do_reload] = 1'b0;
        end
        for (int r = 0; r < NUM_REQ; r++) begin
            if (!m_valid[r]) begin
                rand_fields(r);
                if (rnd_en && m_left[r] > 0 && $urandom_range(0, 3) == 0) m_valid[r] = 1'b1;
            end
        end
        apb_rdata = rd_force_en ? rd_force : DATA_W'($urandom);
        if (t_act && t_id != 2'd0 && cyc >= t_t0 + 2 && cyc < t_done) begin
            apb_ready = (cyc == t_t0 + 2 + t_w);
            if (apb_ready) t_rd = apb_rdata;
        end else begin
            apb_ready = 1'($urandom);
        end
        drive();
    endtask

    task automatic wait_quiet(input int limit, input string tag);
        int n;
        n = 0;
        while ((m_valid != '0 || (t_act && cyc < t_done)) && n < limit) begin
            step();
            n++;
        end
        chk(tag, 32'(n < limit), 32'd1);
        if (cyc >= t_done) t_act = 1'b0;
        repeat (2) step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b0;
        m_valid = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            m_left[r] = 0;
            rand_fields(r);
        end
        apb_ready = 1'b0;
        apb_rdata = '0;
        drive();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_req_done", 32'(req_done), 32'd0);
        chk("reset_rsp_rdata", 32'(rsp_rdata), 32'd0);
        chk("reset_rsp_err", 32'(rsp_err), 32'd0);
        chk("reset_apb_sel", 32'(apb_sel), 32'd0);
        chk("reset_apb_enable", 32'(apb_enable), 32'd0);
        chk("reset_apb_write", 32'(apb_write), 32'd0);
        chk("reset_apb_addr", 32'(apb_addr), 32'd0);
        chk("reset_apb_wdata", 32'(apb_wdata), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        last  = NUM_REQ - 1;

        // Single zero-wait read returning 0xA5
        rd_force_en = 1'b1; rd_force = 8'hA5;
        w_q.push_back(0);
        set_req(0, 1'b0, 2'd2, 8'h10, 8'h00, 1);
        wait_quiet(20, "single_read_bound");
        rd_force_en = 1'b0;

        // Write stretched by four wait states
        w_q.push_back(4);
        set_req(0, 1'b1, 2'd1, 8'h04, 8'h3C, 1);
        wait_quiet(20, "wait_write_bound");

        // Two requesters held valid for two transfers each
        set_req(0, 1'b0, 2'd3, 8'h21, 8'h11, 2);
        set_req(1, 1'b1, 2'd1, 8'h42, 8'h22, 2);
        wait_quiet(80, "round_robin_bound");

        // Unselected slave id
        set_req(1, 1'b0, 2'd0, 8'h55, 8'h66, 1);
        wait_quiet(10, "illegal_id_bound");

        // Reset in the middle of an ACCESS wait state
        w_q.push_back(6);
        set_req(0, 1'b0, 2'd3, 8'h77, 8'h00, 1);
        n = 0;
        while (!(t_act && t_id != 2'd0 && cyc == t_t0 + 4) && n < 40) begin
            step();
            n++;
        end
        chk("reach_access_wait", 32'(n < 40), 32'd1);
        set_req(1, 1'b1, 2'd2, 8'h88, 8'h99, 1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midreset_apb_sel", 32'(apb_sel), 32'd0);
        chk("midreset_apb_enable", 32'(apb_enable), 32'd0);
        chk("midreset_req_done", 32'(req_done), 32'd0);
        chk("midreset_rsp_err", 32'(rsp_err), 32'd0);
        t_act = 1'b0; reload_g = -1; last = NUM_REQ - 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        wait_quiet(60, "post_reset_bound");

`ifdef APB_TIMEOUT_EN
        // Stuck slave aborts; one cycle short of the limit still completes
        begin
            int tw [3];
            tw[0] = TIMEOUT + 2; tw[1] = TIMEOUT - 1; tw[2] = TIMEOUT;
            for (int i = 0; i < 3; i++) begin
                w_q.push_back(tw[i]);
                set_req(0, 1'b0, 2'd1, 8'h30, 8'h00, 1);
                wait_quiet(40, "timeout_bound");
            end
        end
`endif

        // Random traffic from all requesters
        rnd_en = 1'b1;
        for (int r = 0; r < NUM_REQ; r++) m_left[r] = $urandom_range(3, 6);
        wait_quiet(3000, "random_bound");
        rnd_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_apb_master_arbiter
`default_nettype wire

// File: doc/apb_master_arbiter.md
Name: apb_master_arbiter

Overview:
- Shares one APB bus between NUM_REQ local requesters, using round-robin arbitration.
- Sequences every granted transfer through the APB SETUP and ACCESS phases and drives the encoded 2-bit slave select. Slave ids are 1..3; 00 means no slave selected.
- Sits between the I2C/control-side requesters and the APB_Slave instances. Returns read data and a completion pulse to the granted requester.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- ADDR_W, 8, APB address width.
- DATA_W, 8, APB data width.
- TIMEOUT, 255, maximum ACCESS wait cycles before abort (used only with APB_TIMEOUT_EN).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester transfer request; held until its req_done.
- req_write  in  NUM_REQ  1 = write, 0 = read.
- req_id  in  2*NUM_REQ  target slave id per requester.
- req_addr  in  ADDR_W*NUM_REQ  address per requester.
- req_wdata  in  DATA_W*NUM_REQ  write data per requester.
- req_done  out  NUM_REQ  one-cycle completion pulse, one-hot.
- rsp_rdata  out  DATA_W  read data; valid while req_done is high.
- rsp_err  out  1  error flag; valid while req_done is high.
- apb_sel  out  2  encoded slave select.
- apb_enable  out  1  ACCESS-phase enable.
- apb_write  out  1  transfer direction.
- apb_addr  out  ADDR_W  transfer address.
- apb_wdata  out  DATA_W  transfer write data.
- apb_rdata  in  DATA_W  slave read data.
- apb_ready  in  1  slave ready / wait-state control.

Behaviour:
- Reset value (reset = 0, immediate) of every output is 0: req_done, rsp_rdata, rsp_err, apb_sel, apb_enable, apb_write, apb_addr, apb_wdata.
  - State returns to IDLE and the round-robin pointer resets to requester 0.
  - Reset mid-transfer drops apb_sel and apb_enable at once; no req_done is issued.
- State machine: IDLE, SETUP, ACCESS.
- IDLE:
  - Eligible set = req_valid & ~req_done. This masks the requester completing this cycle; it drops req_valid on the same edge.
  - If the set is non-empty, grant the first eligible requester at or after (last_grant+1) mod NUM_REQ.
  - Latch that requester's write, id, addr and wdata into registers. All apb_* outputs are driven only from these registers.
  - If the latched id is 00: no bus cycle; next cycle pulse req_done[g] with rsp_err=1 and rsp_rdata=0; stay in IDLE.
  - Otherwise go to SETUP.
- SETUP (exactly 1 cycle): apb_sel=id, apb_enable=0, write/addr/wdata valid. Then go to ACCESS.
- ACCESS:
  - apb_sel held, apb_enable=1.
  - apb_ready=0: stay in ACCESS with all outputs stable (wait state).
  - apb_ready=1: capture apb_rdata into rsp_rdata (reads only; writes give 0) and set rsp_err=0.
  - On the next edge: req_done[g]=1 for one cycle, apb_sel=0, apb_enable=0, state returns to IDLE, last_grant=g.
- Latency: zero-wait transfer is grant edge → SETUP → ACCESS → req_done, i.e. done 3 cycles after the grant edge. Each wait state adds 1 cycle.
- Minimum spacing between back-to-back transfers: one IDLE cycle.
- Simultaneous requests: strictly round-robin. A requester is never granted twice in a row while another is eligible.
- req_valid dropping mid-transfer is ignored; the latched transfer completes.
- Inputs of requesters that are not granted are never sampled.

Optional Feature:
- Macro APB_TIMEOUT_EN.
- Defined:
  - An 8-bit wait counter clears on entry to ACCESS and increments each ACCESS cycle with apb_ready=0.
  - When the count reaches TIMEOUT, abort: apb_sel=0, apb_enable=0, req_done[g] pulses with rsp_err=1 and rsp_rdata=0, state returns to IDLE.
  - apb_ready=1 in the same cycle as the count reaches TIMEOUT wins: normal completion.
- Undefined: ACCESS waits indefinitely; rsp_err is set only for id 00.

Decomposition:
- apb_pkg holds:
  - the state typedef (IDLE/SETUP/ACCESS);
  - APB_ID_W=2;
  - APB_ID_NONE=2'b00;
  - TIMEOUT_CNT_W=8.
- Sub-module rr_arbiter: purely combinational plus the last_grant register.
  - Inputs: eligible vector, enable.
  - Outputs: one-hot grant, grant index.

Test Plan:
- Single read: req 0 reads id=2, addr=0x10, slave returns 0xA5 with apb_ready tied 1 → apb_sel=2 for 2 cycles, apb_enable high in the 2nd only; req_done[0] 3 cycles after grant; rsp_rdata=0xA5, rsp_err=0.
- Wait states: write id=1, addr=0x04, wdata=0x3C, apb_ready low for 4 ACCESS cycles → addr, wdata and sel stable throughout; req_done[0] exactly 4 cycles later than the zero-wait case.
- Round-robin: req 0 and req 1 both held valid for 4 transfers → grant order 0, 1, 0, 1; one IDLE cycle between each pair of transfers.
- Illegal id: req 1 with id=0 → no apb_sel activity; req_done[1] with rsp_err=1 the cycle after grant.
- Reset mid-ACCESS: assert reset during a wait state → apb_sel, apb_enable and req_done go to 0 immediately; after release a pending req 0 is re-granted first.
- APB_TIMEOUT_EN with TIMEOUT=8, apb_ready stuck 0 → abort after 8 wait cycles; req_done with rsp_err=1 and rsp_rdata=0; bus returns to apb_sel=0.
